// File: rtl/bypass_controller.sv
// bypass_controller: registers per-operand bypass selects by matching RR sources
// against producers issued one and two cycles earlier.
module bypass_controller #(
   parameter  int LANES  = 2,
   parameter  int PREG_W = 7,
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    flush,
   input  logic [LANES-1:0]        rrValid,
   input  logic [LANES*PREG_W-1:0] phySrcA,
   input  logic [LANES*PREG_W-1:0] phySrcB,
   input  logic [LANES*PREG_W-1:0] phyDst,
   input  logic [LANES-1:0]        readA,
   input  logic [LANES-1:0]        readB,
   input  logic [LANES-1:0]        writeReg,
   output logic [LANES*2-1:0]      ctrlASel,
   output logic [LANES*LW-1:0]     ctrlALane,
   output logic [LANES*2-1:0]      ctrlBSel,
   output logic [LANES*LW-1:0]     ctrlBLane
);
   logic [LANES-1:0]             s1_valid, s2_valid;
   logic [LANES-1:0][PREG_W-1:0] s1_dst, s2_dst;
   logic [LANES-1:0][1:0]        a_sel, b_sel;
   logic [LANES-1:0][LW-1:0]     a_lane, b_lane;
   logic [PREG_W-1:0]            src_a, src_b;

   // Scan high-to-low so the lowest lane wins; stage 1 is scanned last so it beats stage 2.
   always_comb begin
      a_sel  = '0;
      a_lane = '0;
      b_sel  = '0;
      b_lane = '0;
      src_a  = '0;
      src_b  = '0;
      for (int i = 0; i < LANES; i++) begin
         src_a = phySrcA[i*PREG_W +: PREG_W];
         src_b = phySrcB[i*PREG_W +: PREG_W];
         for (int j = LANES - 1; j >= 0; j--) begin
            if (s2_valid[j] && s2_dst[j] == src_a) begin
               a_sel[i]  = 2'd2;
               a_lane[i] = LW'(j);
            end
            if (s2_valid[j] && s2_dst[j] == src_b) begin
               b_sel[i]  = 2'd2;
               b_lane[i] = LW'(j);
            end
         end
         for (int j = LANES - 1; j >= 0; j--) begin
            if (s1_valid[j] && s1_dst[j] == src_a) begin
               a_sel[i]  = 2'd1;
               a_lane[i] = LW'(j);
            end
            if (s1_valid[j] && s1_dst[j] == src_b) begin
               b_sel[i]  = 2'd1;
               b_lane[i] = LW'(j);
            end
         end
         if (!(rrValid[i] && readA[i])) begin
            a_sel[i]  = '0;
            a_lane[i] = '0;
         end
         if (!(rrValid[i] && readB[i])) begin
            b_sel[i]  = '0;
            b_lane[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= '0;
         s2_valid  <= '0;
         s1_dst    <= '0;
         s2_dst    <= '0;
         ctrlASel  <= '0;
         ctrlALane <= '0;
         ctrlBSel  <= '0;
         ctrlBLane <= '0;
      end else if (flush) begin
         s1_valid  <= '0;
         s2_valid  <= '0;
         ctrlASel  <= '0;
         ctrlALane <= '0;
         ctrlBSel  <= '0;
         ctrlBLane <= '0;
      end else if (!stall) begin
         s1_valid  <= rrValid & writeReg;
         s1_dst    <= phyDst;
         s2_valid  <= s1_valid;
         s2_dst    <= s1_dst;
         ctrlASel  <= a_sel;
         ctrlALane <= a_lane;
         ctrlBSel  <= b_sel;
         ctrlBLane <= b_lane;
      end
   end
endmodule

// File: tb/tb_bypass_controller.sv
// tb_bypass_controller: directed scenarios with hand-computed bypass selects.
module tb_bypass_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  rrValid = '0, readA = '0, readB = '0, writeReg = '0;
   logic [13:0] phySrcA = '0, phySrcB = '0, phyDst = '0;
   logic [3:0]  ctrlASel, ctrlBSel;
   logic [1:0]  ctrlALane, ctrlBLane;
   int          checks = 0;
   int          errors = 0;

   bypass_controller dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .rrValid(rrValid),
      .phySrcA(phySrcA), .phySrcB(phySrcB), .phyDst(phyDst), .readA(readA),
      .readB(readB), .writeReg(writeReg), .ctrlASel(ctrlASel), .ctrlALane(ctrlALane),
      .ctrlBSel(ctrlBSel), .ctrlBLane(ctrlBLane)
   );

   always #5 clk = ~clk;

   // Select value 3 must never appear on any lane.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ctrlASel[i*2 +: 2] === 2'd3 || ctrlBSel[i*2 +: 2] === 2'd3) begin
            errors++;
            $display("FAIL sel3 lane%0d: A=%0d B=%0d, required never 3", i, ctrlASel[i*2 +: 2], ctrlBSel[i*2 +: 2]);
         end
      end
   end

   task automatic drive(input logic [1:0] rv, ra, rb, wr, input logic [6:0] a0, a1, b0, b1, d0, d1);
      rrValid  = rv;
      readA    = ra;
      readB    = rb;
      writeReg = wr;
      phySrcA  = {a1, a0};
      phySrcB  = {b1, b0};
      phyDst   = {d1, d0};
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #2;
      checks++;
      if (ctrlASel !== 4'd0 || ctrlBSel !== 4'd0 || ctrlALane !== 2'd0 || ctrlBLane !== 2'd0) begin
         errors++;
         $display("FAIL reset: A=%h/%h B=%h/%h, required all 0", ctrlASel, ctrlALane, ctrlBSel, ctrlBLane);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      checks++;
      if (ctrlASel !== 4'd0 || ctrlBSel !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle: A=%h B=%h, required 0", ctrlASel, ctrlBSel);
      end
   endtask

   task automatic test_back_to_back();
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 5, 0);
      step();
      drive(2'b10, 2'b10, 0, 0, 0, 5, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel[3:2] !== 2'd1 || ctrlALane[1] !== 1'b0) begin
         errors++;
         $display("FAIL b2b: sel=%0d lane=%0d, required sel=1 lane=0", ctrlASel[3:2], ctrlALane[1]);
      end
      checks++;
      if (ctrlASel[1:0] !== 2'd0) begin
         errors++;
         $display("FAIL b2b_lane0: sel=%0d, required 0", ctrlASel[1:0]);
      end
   endtask

   task automatic test_distance();
      idle();
      drive(2'b10, 0, 0, 2'b10, 0, 0, 0, 0, 0, 9);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(2'b01, 0, 2'b01, 0, 0, 0, 9, 0, 0, 0);
      step();
      checks++;
      if (ctrlBSel[1:0] !== 2'd2 || ctrlBLane[0] !== 1'b1) begin
         errors++;
         $display("FAIL dist2: sel=%0d lane=%0d, required sel=2 lane=1", ctrlBSel[1:0], ctrlBLane[0]);
      end
      idle();
      drive(2'b10, 0, 0, 2'b10, 0, 0, 0, 0, 0, 9);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      drive(2'b01, 0, 2'b01, 0, 0, 0, 9, 0, 0, 0);
      step();
      checks++;
      if (ctrlBSel[1:0] !== 2'd0) begin
         errors++;
         $display("FAIL dist3: sel=%0d, required 0", ctrlBSel[1:0]);
      end
   endtask

   task automatic test_priority();
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 12, 0);
      step();
      drive(2'b10, 0, 0, 2'b10, 0, 0, 0, 0, 0, 12);
      step();
      drive(2'b01, 2'b01, 0, 0, 12, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel[1:0] !== 2'd1 || ctrlALane[0] !== 1'b1) begin
         errors++;
         $display("FAIL prio_stage: sel=%0d lane=%0d, required sel=1 lane=1", ctrlASel[1:0], ctrlALane[0]);
      end
      idle();
      drive(2'b11, 0, 0, 2'b11, 0, 0, 0, 0, 3, 3);
      step();
      drive(2'b10, 0, 2'b10, 0, 0, 0, 0, 3, 0, 0);
      step();
      checks++;
      if (ctrlBSel[3:2] !== 2'd1 || ctrlBLane[1] !== 1'b0) begin
         errors++;
         $display("FAIL prio_lane: sel=%0d lane=%0d, required sel=1 lane=0", ctrlBSel[3:2], ctrlBLane[1]);
      end
   endtask

   task automatic test_gating();
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 5, 0);
      step();
      drive(2'b10, 2'b00, 0, 0, 0, 5, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel !== 4'd0) begin
         errors++;
         $display("FAIL gate_read: sel=%h, required 0", ctrlASel);
      end
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 5, 0);
      step();
      drive(2'b00, 2'b10, 0, 0, 0, 5, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel !== 4'd0) begin
         errors++;
         $display("FAIL gate_valid: sel=%h, required 0", ctrlASel);
      end
      idle();
      drive(2'b01, 0, 0, 2'b00, 0, 0, 0, 0, 5, 0);
      step();
      drive(2'b10, 2'b10, 0, 0, 0, 5, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel !== 4'd0) begin
         errors++;
         $display("FAIL gate_write: sel=%h, required 0", ctrlASel);
      end
   endtask

   task automatic test_stall_flush();
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 7, 0);
      step();
      drive(2'b10, 2'b10, 0, 0, 0, 7, 0, 0, 0, 0);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (ctrlASel !== 4'd0) begin
            errors++;
            $display("FAIL stall_hold%0d: sel=%h, required 0", k, ctrlASel);
         end
      end
      stall = 1'b0;
      step();
      checks++;
      if (ctrlASel[3:2] !== 2'd1 || ctrlALane[1] !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: sel=%0d lane=%0d, required sel=1 lane=0", ctrlASel[3:2], ctrlALane[1]);
      end
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 7, 0);
      step();
      drive(2'b10, 0, 0, 2'b10, 0, 0, 0, 0, 0, 7);
      step();
      drive(2'b01, 2'b01, 0, 0, 7, 0, 0, 0, 0, 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (ctrlASel !== 4'd0 || ctrlALane !== 2'd0) begin
         errors++;
         $display("FAIL flush_out: sel=%h lane=%h, required 0", ctrlASel, ctrlALane);
      end
      step();
      checks++;
      if (ctrlASel !== 4'd0) begin
         errors++;
         $display("FAIL flush_after: sel=%h, required 0", ctrlASel);
      end
   endtask

   task automatic test_async_reset();
      idle();
      drive(2'b01, 0, 0, 2'b01, 0, 0, 0, 0, 5, 0);
      step();
      drive(2'b10, 2'b10, 0, 0, 0, 5, 0, 0, 0, 0);
      step();
      checks++;
      if (ctrlASel[3:2] !== 2'd1) begin
         errors++;
         $display("FAIL arst_pre: sel=%0d, required 1", ctrlASel[3:2]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ctrlASel !== 4'd0 || ctrlALane !== 2'd0) begin
         errors++;
         $display("FAIL arst_now: sel=%h lane=%h, required 0", ctrlASel, ctrlALane);
      end
      #1 rst = 1'b0;
      step();
      checks++;
      if (ctrlASel !== 4'd0) begin
         errors++;
         $display("FAIL arst_post: sel=%h, required 0", ctrlASel);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance();
      test_priority();
      test_gating();
      test_stall_flush();
      test_async_reset();
      idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
